// File: rtl/mem_ctrl_if.sv
// Control-unit <-> memory-stage bundle: request/address/write-data towards the
// memory stage, read word plus MDR load and status strobes back.
interface mem_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic              wr_req;
  logic [31:0]       mar_addr;
  logic [DATA_W-1:0] mdr_data;
  logic [DATA_W-1:0] mdatain;
  logic              mdr_ld;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output rd_req, wr_req, mar_addr, mdr_data,
    input  mdatain, mdr_ld, busy, done, err
  );

  modport slave (
    input  rd_req, wr_req, mar_addr, mdr_data,
    output mdatain, mdr_ld, busy, done, err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory stage feeding the MDR: owns a 2**ADDR_W x DATA_W synchronous RAM and
// runs one read/write at a time through IDLE -> WAIT -> ACCESS -> DONE (or ERR).
module mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus
);

  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_op_rd;
  logic [DATA_W-1:0] r_mdatain;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_load;
  logic [ADDR_W-1:0] w_addr;

  // Upper MAR bits are simply dropped, so out-of-range addresses alias.
  assign w_addr = bus.mar_addr[ADDR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.mdr_ld  = 1'b0;
    bus.err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rd_req && bus.wr_req) begin
          w_state_nxt = S_ERR;
        end else if (bus.rd_req || bus.wr_req) begin
          w_load      = 1'b1;
          w_state_nxt = (WS == 4'd0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        bus.busy    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.mdr_ld  = r_op_rd;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        bus.err     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_op_rd   <= 1'b0;
      r_mdatain <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt   <= WS;
        r_addr  <= w_addr;
        r_wdata <= bus.mdr_data;
        r_op_rd <= bus.rd_req;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACCESS && r_op_rd) begin
        r_mdatain <= r_mem[r_addr];
      end
    end
  end

  // RAM array has no reset; an aborted access never reaches S_ACCESS so it never writes.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && !r_op_rd) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign bus.mdatain = r_mdatain;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized scoreboard bench for mem_ctrl: one instance with 2 wait states and
// one with none, both checked against an array-based memory model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_ctrl_if #(.DATA_W(32)) bus0 ();
  mem_ctrl_if #(.DATA_W(32)) bus1 ();

  mem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  mem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // flags = {done, mdr_ld, err}; due = cycle count seen while the pulse is high
  typedef struct packed {
    logic [2:0]  flags;
    logic [31:0] md;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] ref0 [512];
  logic [31:0] ref1 [512];
  logic [31:0] md0 = 32'h0;
  logic [31:0] md1 = 32'h0;
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic get_busy(int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction

  task automatic drv(int sel, logic rd, logic wr, logic [31:0] a, logic [31:0] d);
    if (sel == 0) begin
      bus0.rd_req = rd; bus0.wr_req = wr; bus0.mar_addr = a; bus0.mdr_data = d;
    end else begin
      bus1.rd_req = rd; bus1.wr_req = wr; bus1.mar_addr = a; bus1.mdr_data = d;
    end
  endtask

  task automatic push(int sel, exp_t x);
    if (sel == 0) q0.push_back(x);
    else          q1.push_back(x);
  endtask

  // op: 0 read, 1 write, 2 both requests (collision). poke drives a stray write
  // request one cycle after the sample, which must be ignored.
  task automatic issue(int sel, int op, logic [31:0] addr, logic [31:0] data, bit poke);
    int         ws;
    int         n;
    exp_t       x;
    logic [8:0] a;
    ws = (sel == 0) ? 2 : 0;
    a  = addr[8:0];
    @(negedge clk);
    drv(sel, op != 1, op != 0, addr, data);
    @(posedge clk);
    #1;
    n = cyc;
    if (poke) drv(sel, 1'b0, 1'b1, 32'h010, 32'h11111111);
    else      drv(sel, 1'b0, 1'b0, $urandom, $urandom);
    if (op == 2) begin
      x.flags = 3'b001;
      x.md    = (sel == 0) ? md0 : md1;
      x.due   = n;
      push(sel, x);
      chk("busy_err", {31'b0, get_busy(sel)}, 32'd0);
      @(posedge clk);
      #1;
      drv(sel, 1'b0, 1'b0, $urandom, $urandom);
    end else begin
      if (op == 1) begin
        if (sel == 0) ref0[a] = data; else ref1[a] = data;
        x.flags = 3'b100;
      end else begin
        if (sel == 0) md0 = ref0[a]; else md1 = ref1[a];
        x.flags = 3'b110;
      end
      x.md  = (sel == 0) ? md0 : md1;
      x.due = n + ws + 1;
      push(sel, x);
      // busy through the wait cycles and ACCESS, low once in DONE
      for (int k = 0; k <= ws + 1; k++) begin
        chk("busy", {31'b0, get_busy(sel)}, {31'b0, (k <= ws)});
        @(posedge clk);
        #1;
        if (k == 0) drv(sel, 1'b0, 1'b0, $urandom, $urandom);
      end
    end
  endtask

  task automatic mon(int sel, logic d, logic l, logic e, logic [31:0] md);
    exp_t x;
    if (!(d || l || e)) return;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      chk($sformatf("unexpected_pulse%0d", sel), {29'b0, d, l, e}, 32'd0);
      return;
    end
    x = (sel == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("pulse_kind%0d", sel), {29'b0, d, l, e}, {29'b0, x.flags});
    chk($sformatf("pulse_cycle%0d", sel), 32'(cyc), 32'(x.due));
    chk($sformatf("mdatain%0d", sel), md, x.md);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, bus0.done, bus0.mdr_ld, bus0.err, bus0.mdatain);
      mon(1, bus1.done, bus1.mdr_ld, bus1.err, bus1.mdatain);
    end
  end

  task automatic reset_mid_write();
    @(negedge clk);
    drv(0, 1'b0, 1'b1, 32'h020, 32'h55AA55AA);
    @(posedge clk);
    #1;
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_busy",    {31'b0, bus0.busy},   32'd0);
    chk("rst_mid_done",    {31'b0, bus0.done},   32'd0);
    chk("rst_mid_mdatain", bus0.mdatain,         32'd0);
    md0 = 32'h0;
    md1 = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int op;
    logic [31:0] addr;
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_busy",     {31'b0, bus0.busy},   32'd0);
    chk("rst_done",     {31'b0, bus0.done},   32'd0);
    chk("rst_err",      {31'b0, bus0.err},    32'd0);
    chk("rst_mdr_ld",   {31'b0, bus0.mdr_ld}, 32'd0);
    chk("rst_mdatain",  bus0.mdatain,         32'd0);
    chk("rst_mdatain1", bus1.mdatain,         32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 512; i++) issue(0, 1, 32'(i), $urandom, 1'b0);
    for (int i = 0; i < 512; i++) issue(1, 1, 32'(i), $urandom, 1'b0);

    issue(0, 1, 32'h005, 32'hDEADBEEF, 1'b0);
    issue(0, 0, 32'h005, 32'h0, 1'b0);
    issue(0, 1, 32'h00000205, 32'hABCD1234, 1'b0);
    issue(0, 0, 32'h005, 32'h0, 1'b0);
    issue(0, 2, 32'h030, 32'h77777777, 1'b0);
    issue(0, 0, 32'h030, 32'h0, 1'b0);
    issue(0, 0, 32'h010, 32'h0, 1'b1);
    issue(0, 0, 32'h010, 32'h0, 1'b0);
    reset_mid_write();
    issue(0, 0, 32'h020, 32'h0, 1'b0);
    issue(1, 0, 32'h044, 32'h0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      r    = $urandom_range(0, 9);
      op   = (r < 4 || r >= 8) ? 0 : (r < 7) ? 1 : 2;
      addr = $urandom;
      if (r[0]) addr[8:4] = 5'd0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(i % 4 == 3 ? 1 : 0, op, addr, $urandom, r >= 8);
    end

    repeat (6) @(negedge clk);
    chk("queue_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
